// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, ALUOp encodings, R-type funct values
// and the control-bit bundle carried down the pipeline.
package cpu_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_BAD = 4'd15;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
   } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALUOp/funct to ALU control code decoder; unknown R-type funct
// yields ALU_BAD and raises illegal.
module alu_control
   import cpu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] aluctl,
   output logic       illegal
);

   always_comb begin
      aluctl  = ALU_ADD;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: aluctl = ALU_ADD;
         ALUOP_SUB: aluctl = ALU_SUB;
         ALUOP_OR:  aluctl = ALU_OR;
         default: begin
            case (funct)
               FN_ADD:  aluctl = ALU_ADD;
               FN_SUB:  aluctl = ALU_SUB;
               FN_AND:  aluctl = ALU_AND;
               FN_OR:   aluctl = ALU_OR;
               FN_NOR:  aluctl = ALU_NOR;
               FN_SLT:  aluctl = ALU_SLT;
               default: begin
                  aluctl  = ALU_BAD;
                  illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use bubble insertion.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [1:0]    id_aluop,
   input  logic [5:0]    id_funct,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic          id_alusrc,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          flush,
   input  logic          hold,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic          stall_o,
   output logic [3:0]    ALUctl,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_rd,
   output logic          ex_valid,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg,
   output logic          ex_illegal
);

   ex_ctrl_t      ctrl_reg;
   logic [3:0]    aluctl_reg;
   logic          illegal_reg;
   logic [RW-1:0] rs_reg, rt_reg, rd_reg;
   logic [DW-1:0] rs_data_reg, rt_data_reg, imm_reg;
   logic          alusrc_reg;

   logic [3:0]    dec_aluctl;
   logic          dec_illegal;
   logic          load_use;
   ex_ctrl_t      id_ctrl;
   logic [DW-1:0] rs_fwd, rt_fwd;

   alu_control u_alu_control (
      .aluop   (id_aluop),
      .funct   (id_funct),
      .aluctl  (dec_aluctl),
      .illegal (dec_illegal)
   );

   assign load_use = ctrl_reg.valid & ctrl_reg.memread & id_valid & (rd_reg != '0)
                   & ((rd_reg == id_rs) | ((rd_reg == id_rt) & ~id_alusrc));
   assign stall_o  = load_use & ~flush;

   // An invalid ID slot must never carry side effects into EX.
   assign id_ctrl = '{valid:    id_valid,
                      regwrite: id_valid & id_regwrite,
                      memread:  id_valid & id_memread,
                      memwrite: id_valid & id_memwrite,
                      memtoreg: id_valid & id_memtoreg};

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg    <= '0;
         aluctl_reg  <= '0;
         illegal_reg <= 1'b0;
         rs_reg      <= '0;
         rt_reg      <= '0;
         rd_reg      <= '0;
         rs_data_reg <= '0;
         rt_data_reg <= '0;
         imm_reg     <= '0;
         alusrc_reg  <= 1'b0;
      end else if (flush || (!hold && load_use)) begin
         ctrl_reg    <= '0;
         aluctl_reg  <= ALU_ADD;
         illegal_reg <= 1'b0;
      end else if (!hold) begin
         ctrl_reg    <= id_ctrl;
         aluctl_reg  <= dec_aluctl;
         illegal_reg <= dec_illegal & id_valid;
         rs_reg      <= id_rs;
         rt_reg      <= id_rt;
         rd_reg      <= id_rd;
         rs_data_reg <= id_rs_data;
         rt_data_reg <= id_rt_data;
         imm_reg     <= id_imm;
         alusrc_reg  <= id_alusrc;
      end
   end

   // EX/MEM is applied last so it wins over MEM/WB; r0 never forwards.
   always_comb begin
      rs_fwd = rs_data_reg;
      rt_fwd = rt_data_reg;
      if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_reg)) rs_fwd = memwb_result;
      if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_reg)) rt_fwd = memwb_result;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_reg)) rs_fwd = exmem_result;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_reg)) rt_fwd = exmem_result;
   end

   assign A             = rs_fwd;
   assign B             = alusrc_reg ? imm_reg : rt_fwd;
   assign ex_store_data = rt_fwd;
   assign ALUctl        = aluctl_reg;
   assign ex_illegal    = illegal_reg;
   assign ex_rd         = rd_reg;
   assign ex_valid      = ctrl_reg.valid;
   assign ex_regwrite   = ctrl_reg.regwrite;
   assign ex_memread    = ctrl_reg.memread;
   assign ex_memwrite   = ctrl_reg.memwrite;
   assign ex_memtoreg   = ctrl_reg.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, load-use stall, forwarding, flush/hold
// priority and reset, checked with immediate assertions.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [1:0]  id_aluop;
   logic [5:0]  id_funct;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_alusrc;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        flush, hold;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        stall_o;
   logic [3:0]  ALUctl;
   logic [31:0] A, B, ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluop(id_aluop),
      .id_funct(id_funct), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_alusrc(id_alusrc), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .flush(flush),
      .hold(hold), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
      .memwb_rd(memwb_rd), .memwb_result(memwb_result), .stall_o(stall_o),
      .ALUctl(ALUctl), .A(A), .B(B), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic src, input logic [31:0] imm,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
      id_valid = v; id_aluop = op; id_funct = fn;
      id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_alusrc = src; id_imm = imm;
      id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = m2r;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; hold = 1'b0;
      exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
      set_id(1, 2'b10, 6'h20, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 0, 32'h0, 1, 0, 0, 0);
      step();
      step();
      $display("reset: ex_valid=%0d ALUctl=%0d A=%0h B=%0h", ex_valid, ALUctl, A, B);
      chk("rst_valid", ex_valid, 0);
      chk("rst_aluctl", ALUctl, 0);
      chk("rst_rd", ex_rd, 0);
      chk("rst_a", A, 0);
      chk("rst_b", B, 0);
      chk("rst_regwrite", ex_regwrite, 0);
      chk("rst_illegal", ex_illegal, 0);

      // slt r3, r1, r2
      reset = 1'b0;
      set_id(1, 2'b10, 6'h2A, 5'd1, 5'd2, 5'd3, 32'd3, 32'd9, 0, 32'h0, 1, 0, 0, 0);
      step();
      $display("slt: ALUctl=%0d A=%0h B=%0h valid=%0d", ALUctl, A, B, ex_valid);
      chk("slt_aluctl", ALUctl, 7);
      chk("slt_a", A, 3);
      chk("slt_b", B, 9);
      chk("slt_valid", ex_valid, 1);
      chk("slt_rd", ex_rd, 3);

      // lw r8, 4(r1)
      set_id(1, 2'b00, 6'h00, 5'd1, 5'd8, 5'd8, 32'd100, 32'h0, 1, 32'd4, 1, 1, 0, 1);
      step();
      $display("lw: ALUctl=%0d A=%0h B=%0h memread=%0d", ALUctl, A, B, ex_memread);
      chk("lw_aluctl", ALUctl, 2);
      chk("lw_a", A, 100);
      chk("lw_b", B, 4);
      chk("lw_memread", ex_memread, 1);

      // add r10, r8, r9 depends on the load
      set_id(1, 2'b10, 6'h20, 5'd8, 5'd9, 5'd10, 32'h99, 32'h55, 0, 32'h0, 1, 0, 0, 0);
      #1;
      $display("loaduse: stall_o=%0d", stall_o);
      chk("lu_stall", stall_o, 1);
      step();
      $display("bubble: ex_valid=%0d regwrite=%0d stall_o=%0d", ex_valid, ex_regwrite, stall_o);
      chk("bub_valid", ex_valid, 0);
      chk("bub_regwrite", ex_regwrite, 0);
      chk("bub_aluctl", ALUctl, 2);
      chk("bub_stall", stall_o, 0);
      step();
      $display("issue: ex_valid=%0d rd=%0d", ex_valid, ex_rd);
      chk("iss_valid", ex_valid, 1);
      chk("iss_rd", ex_rd, 10);
      chk("iss_stall", stall_o, 0);

      // forwarding onto rs=8, rt=9
      exmem_regwrite = 1; exmem_rd = 5'd8; exmem_result = 32'h11;
      memwb_regwrite = 1; memwb_rd = 5'd8; memwb_result = 32'h22;
      #1;
      $display("fwd both: A=%0h", A);
      chk("fwd_exmem_prio", A, 32'h11);
      exmem_rd = 5'd0;
      #1;
      $display("fwd memwb: A=%0h", A);
      chk("fwd_memwb", A, 32'h22);
      exmem_rd = 5'd9; exmem_result = 32'h33;
      #1;
      $display("fwd rt: B=%0h store=%0h", B, ex_store_data);
      chk("fwd_rt_b", B, 32'h33);
      chk("fwd_rt_store", ex_store_data, 32'h33);
      exmem_regwrite = 0; memwb_regwrite = 0;
      #1;
      $display("no fwd: A=%0h B=%0h", A, B);
      chk("nofwd_a", A, 32'h99);
      chk("nofwd_b", B, 32'h55);
      memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'h44;
      #1;
      chk("r0_nofwd", A, 32'h99);
      memwb_regwrite = 0;

      // illegal funct with immediate B
      set_id(1, 2'b10, 6'h03, 5'd6, 5'd4, 5'd7, 32'h1, 32'h77, 1, 32'hFFFF_FFFC, 0, 0, 1, 0);
      step();
      $display("illegal: ALUctl=%0d ill=%0d B=%0h store=%0h", ALUctl, ex_illegal, B, ex_store_data);
      chk("ill_aluctl", ALUctl, 15);
      chk("ill_flag", ex_illegal, 1);
      chk("imm_b", B, 32'hFFFF_FFFC);
      chk("store_plain", ex_store_data, 32'h77);
      exmem_regwrite = 1; exmem_rd = 5'd4; exmem_result = 32'hABC;
      #1;
      $display("store fwd: B=%0h store=%0h", B, ex_store_data);
      chk("store_fwd", ex_store_data, 32'hABC);
      chk("imm_b_fwd", B, 32'hFFFF_FFFC);
      exmem_regwrite = 0;

      // hold with load-use, then flush dominates
      set_id(1, 2'b00, 6'h00, 5'd1, 5'd8, 5'd8, 32'd200, 32'h0, 1, 32'd8, 1, 1, 0, 1);
      step();
      set_id(1, 2'b10, 6'h25, 5'd8, 5'd2, 5'd11, 32'h1, 32'h2, 0, 32'h0, 1, 0, 0, 0);
      hold = 1;
      #1;
      chk("hold_stall", stall_o, 1);
      step();
      $display("hold: valid=%0d memread=%0d rd=%0d", ex_valid, ex_memread, ex_rd);
      chk("hold_valid", ex_valid, 1);
      chk("hold_memread", ex_memread, 1);
      chk("hold_rd", ex_rd, 8);
      flush = 1;
      #1;
      $display("flush: stall_o=%0d", stall_o);
      chk("flush_stall", stall_o, 0);
      step();
      $display("flushed: valid=%0d rw=%0d mr=%0d mw=%0d m2r=%0d", ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg);
      chk("fl_valid", ex_valid, 0);
      chk("fl_regwrite", ex_regwrite, 0);
      chk("fl_memread", ex_memread, 0);
      chk("fl_memwrite", ex_memwrite, 0);
      chk("fl_memtoreg", ex_memtoreg, 0);
      flush = 0; hold = 0;

      // or via aluop 11, then reset mid-stream
      set_id(1, 2'b11, 6'h00, 5'd12, 5'd13, 5'd14, 32'hF0, 32'h0F, 0, 32'h0, 1, 1, 0, 1);
      step();
      chk("or_aluctl", ALUctl, 1);
      chk("or_valid", ex_valid, 1);
      reset = 1;
      set_id(1, 2'b01, 6'h00, 5'd14, 5'd14, 5'd15, 32'h5, 32'h5, 0, 32'h0, 1, 0, 0, 0);
      step();
      $display("midreset: valid=%0d ALUctl=%0d A=%0h B=%0h stall=%0d", ex_valid, ALUctl, A, B, stall_o);
      chk("mr_valid", ex_valid, 0);
      chk("mr_aluctl", ALUctl, 0);
      chk("mr_memread", ex_memread, 0);
      chk("mr_a", A, 0);
      chk("mr_b", B, 0);
      chk("mr_stall", stall_o, 0);
      reset = 0;
      step();
      chk("post_sub_aluctl", ALUctl, 6);
      chk("post_valid", ex_valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded instruction fields at the ID/EX boundary.
- Generates the registered 4-bit ALU control code from ALUOp/funct.
- Applies EX/MEM and MEM/WB operand forwarding, then drives the ALU's ALUctl/A/B.
- Detects load-use hazards and inserts a bubble, with stall back to IF/ID.

Parameters:
- DW, 32, datapath width of operands, immediate and forwarded results.
- RW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or.
- id_funct  in  6  instruction funct field.
- id_rs_data, id_rt_data  in  DW  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_alusrc  in  1  1 selects immediate for B.
- id_rs, id_rt, id_rd  in  RW  source addresses and destination address.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits.
- flush  in  1  branch/jump squash.
- hold  in  1  global pipeline freeze.
- exmem_regwrite  in  1; exmem_rd  in  RW; exmem_result  in  DW  EX/MEM forward source.
- memwb_regwrite  in  1; memwb_rd  in  RW; memwb_result  in  DW  MEM/WB forward source.
- stall_o  out  1  load-use stall to PC and IF/ID.
- ALUctl  out  4  registered ALU op code.
- A, B  out  DW  forwarded ALU operands.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_rd  out  RW; ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1.
- ex_illegal  out  1  unknown R-type funct.

Behaviour:
- Reset, synchronous: all stage registers clear to 0.
  - ex_valid, all control bits, ex_rd, ALUctl and ex_illegal read 0.
  - A and B show the forwarded values of cleared registers.
- ALU code decode, performed before the register:
  - aluop 00 → 2 (add); 01 → 6 (sub); 11 → 1 (or).
  - aluop 10, by funct: 0x20 → 2, 0x22 → 6, 0x24 → 0, 0x25 → 1, 0x27 → 12, 0x2A → 7.
  - Any other funct → 15 with illegal=1. The ALU outputs 0 for code 15.
- Load-use detect (combinational): load_use = ex_valid & ex_memread & id_valid & ex_rd != 0 & (ex_rd == id_rs | (ex_rd == id_rt & ~id_alusrc)). stall_o = load_use & ~flush.
- Register update priority per clock edge:
  - reset: clear.
  - else flush: bubble, i.e. ex_valid and all control bits 0; data fields don't-care.
  - else hold: keep all contents.
  - else load_use: bubble.
  - else: load ID fields; ex_valid = id_valid. When id_valid=0, control bits load as 0.
- Latency: one cycle from ID inputs to EX outputs.
- Forwarding (combinational from registered rs/rt):
  - A = exmem_result if exmem_regwrite & exmem_rd != 0 & exmem_rd == rs_q.
  - Else A = memwb_result if the same condition holds against memwb.
  - Else A = rs_data_q.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
  - rt_fwd is derived identically. B = alusrc_q ? imm_q : rt_fwd. ex_store_data = rt_fwd.
- Bubble behaviour: ALUctl is held at 2 in a bubble. This is harmless because no side-effect controls are set.
- hold=1 with load_use=1: contents are held. stall_o still asserts, so IF/ID also freezes.
- Mid-operation reset: discards the in-flight instruction; the first post-reset cycle is a bubble.

Decomposition:
- Shared package cpu_pkg:
  - ALUctl code constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_BAD=15.
  - ALUOp encodings and funct constants.
- One natural sub-module: alu_control, the combinational aluop/funct → ALUctl/illegal decoder. It is reused by any future multi-cycle core.
- Forwarding muxes stay inline.

Test Plan:
- R-type funct 0x2A, aluop 10, rs_data=3, rt_data=9, no forwarding → next cycle ALUctl=7, A=3, B=9, ex_valid=1.
- lw into r8 in EX, next ID instruction reads rs=8 → stall_o=1 for one cycle; following cycle ex_valid=0 and ex_regwrite=0; then the instruction issues.
- exmem_rd=5 with result 0x11, memwb_rd=5 with result 0x22, rs_q=5 → A=0x11. Same case with exmem_rd=0 → A=0x22.
- flush asserted together with load_use and hold → stall_o=0; after the edge ex_valid=0 and all controls 0.
- aluop 10, funct 0x03 → ALUctl=15, ex_illegal=1. Also: alusrc=1, imm=0xFFFFFFFC → B=0xFFFFFFFC, ex_store_data = forwarded rt.
- reset asserted mid-stream → outputs clear to 0 on the next edge and stall_o=0 while the register is empty.
